// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared constants, FSM state type and bit-order helper for the SPI register slave
package spi_slave_pkg;

  localparam int CMD_W  = 8;
  localparam int RW_BIT = 7;

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} spi_state_e;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] reverse_bits(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - rx/tx shift register pair; wire bit order handled at the word boundary
module spi_slave_shifter
  import spi_slave_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              rx_shift,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] rx_word,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_shift,
  output logic              tx_bit
);

  logic [DATA_W-1:0] rx_q, tx_q, rx_raw, tx_ord;

  // Both registers always shift MSB-side; LSB-first framing is a reversal at load and at capture.
  assign rx_raw  = {rx_q[DATA_W-2:0], rx_bit};
  assign rx_word = MSB_FIRST ? rx_raw  : DATA_W'(reverse_bits(32'(rx_raw), DATA_W));
  assign tx_ord  = MSB_FIRST ? tx_data : DATA_W'(reverse_bits(32'(tx_data), DATA_W));
  assign tx_bit  = tx_q[DATA_W-1];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rx_q <= '0;
      tx_q <= '0;
    end else begin
      if (rx_shift) rx_q <= rx_raw;
      if (tx_load) tx_q <= tx_ord;
      else if (tx_shift) tx_q <= {tx_q[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI slave exposing NREGS registers with single/burst read and write
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NREGS     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    SPI_clk_x,
  input  logic                    HRESETn,
  input  logic                    spi_ss_i,
  input  logic                    spi_mosi_i,
  output logic                    spi_miso_o,
  output logic [NREGS*DATA_W-1:0] regs_o,
  output logic                    wr_toggle_o,
  output logic [6:0]              last_addr_o
);

  localparam int CNT_W = $clog2(DATA_W > 8 ? DATA_W : 8) + 1;

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        addr_q, addr_d, rd_addr;
  logic              armed_q, frame_clr_n;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] rx_word, rd_data, tx_data;
  logic [CMD_W-1:0]  cmd_byte;
  logic              rx_shift, tx_load, tx_shift, tx_bit, commit;

  function automatic logic [6:0] addr_adv(input logic [6:0] a);
    if (int'(a) == NREGS - 1) return 7'd0;
    return a + 7'd1;
  endfunction

  assign frame_clr_n = HRESETn & ~spi_ss_i;

  // A falling select proves select was high since reset, so the tail of a frame cut by reset is ignored.
  always_ff @(negedge spi_ss_i or negedge HRESETn) begin
    if (!HRESETn) armed_q <= 1'b0;
    else          armed_q <= 1'b1;
  end

  spi_slave_shifter #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_shifter (
    .clk      (SPI_clk_x),
    .clr_n    (frame_clr_n),
    .rx_shift (rx_shift),
    .rx_bit   (spi_mosi_i),
    .rx_word  (rx_word),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .tx_shift (tx_shift),
    .tx_bit   (tx_bit)
  );

  assign cmd_byte = MSB_FIRST ? rx_word[CMD_W-1:0] : rx_word[DATA_W-1 -: CMD_W];
  assign rd_addr  = (state_q == CMD) ? cmd_byte[6:0] : addr_adv(addr_q);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(rd_addr) == i) rd_data = regs_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rx_shift = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    tx_data  = '0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q) begin
          rx_shift = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = CMD;
        end
      end
      CMD: begin
        rx_shift = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CMD_W - 1)) begin
          cnt_d  = '0;
          addr_d = cmd_byte[6:0];
          if (cmd_byte[RW_BIT]) begin
            state_d = RD;
            tx_load = 1'b1;
            tx_data = rd_data;
          end else begin
            state_d = WR;
          end
        end
      end
      WR: begin
        rx_shift = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d  = '0;
          commit = (int'(addr_q) < NREGS);
          addr_d = addr_adv(addr_q);
        end
      end
      RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          addr_d  = addr_adv(addr_q);
          tx_load = 1'b1;
          tx_data = rd_data;
        end else begin
          tx_shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SPI_clk_x or negedge frame_clr_n) begin
    if (!frame_clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge SPI_clk_x or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wr_toggle_o <= 1'b0;
      last_addr_o <= '0;
    end else if (commit) begin
      for (int i = 0; i < NREGS; i++) begin
        if (int'(addr_q) == i) regs_q[i] <= rx_word;
      end
      wr_toggle_o <= ~wr_toggle_o;
      last_addr_o <= addr_q;
    end
  end

  assign spi_miso_o = (state_q == RD) & tx_bit;

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb/tb_spi_slave_regfile.sv - randomized self-checking bench for spi_slave_regfile against a word-level model
module tb_spi_slave_regfile;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;

  logic                    SPI_clk_x = 1'b0;
  logic                    HRESETn;
  logic                    spi_ss_i;
  logic                    spi_mosi_i;
  logic                    spi_miso_o;
  logic [NREGS*DATA_W-1:0] regs_o;
  logic                    wr_toggle_o;
  logic [6:0]              last_addr_o;

  spi_slave_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .MSB_FIRST(1'b1)) dut (
    .SPI_clk_x   (SPI_clk_x),
    .HRESETn     (HRESETn),
    .spi_ss_i    (spi_ss_i),
    .spi_mosi_i  (spi_mosi_i),
    .spi_miso_o  (spi_miso_o),
    .regs_o      (regs_o),
    .wr_toggle_o (wr_toggle_o),
    .last_addr_o (last_addr_o)
  );

  always #5 SPI_clk_x = ~SPI_clk_x;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_regs [NREGS];
  logic              m_toggle;
  logic [6:0]        m_last;
  logic [DATA_W-1:0] tx_words [8];
  logic [DATA_W-1:0] rx_words [9];
  logic              miso_any;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int next_addr(input int a);
    if (a < NREGS) return (a + 1) % NREGS;
    return (a + 1) % 128;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_toggle = 1'b0;
    m_last   = '0;
  endtask

  // Sends 8+ndata bits MSB first (ndata<0 cuts the command short); rst_at>=0 pulses reset after that bit.
  task automatic do_frame(input logic [7:0] cmd, input int ndata, input int rst_at);
    int  nbits;
    int  d;
    logic b;
    nbits    = 8 + ndata;
    miso_any = 1'b0;
    for (int w = 0; w < 9; w++) rx_words[w] = '0;
    @(negedge SPI_clk_x);
    spi_ss_i = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      if (k < 8) b = cmd[7-k];
      else       b = tx_words[(k-8)/DATA_W][DATA_W-1-((k-8)%DATA_W)];
      spi_mosi_i = b;
      @(posedge SPI_clk_x);
      @(negedge SPI_clk_x);
      miso_any = miso_any | spi_miso_o;
      if (k >= 7) begin
        d = k - 7;
        rx_words[d/DATA_W][DATA_W-1-(d%DATA_W)] = spi_miso_o;
      end
      if (k == rst_at) begin
        HRESETn = 1'b0;
        #1;
        HRESETn = 1'b1;
      end
    end
    spi_ss_i   = 1'b1;
    spi_mosi_i = 1'b0;
    #1;
    @(negedge SPI_clk_x);
  endtask

  task automatic model_frame(input logic [7:0] cmd, input int ndata);
    int a;
    int nw;
    a  = int'(cmd[6:0]);
    nw = (ndata < 0) ? 0 : ndata / DATA_W;
    for (int w = 0; w < nw; w++) begin
      if (cmd[7]) begin
        check_eq($sformatf("rd_word%0d_addr%0d", w, a), 32'(rx_words[w]),
                 (a < NREGS) ? 32'(m_regs[a]) : 32'd0);
      end else if (a < NREGS) begin
        m_regs[a] = tx_words[w];
        m_toggle  = ~m_toggle;
        m_last    = 7'(a);
      end
      a = next_addr(a);
    end
    if (!cmd[7]) check_eq("miso_zero_in_write", 32'(miso_any), 32'd0);
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < NREGS; i++)
      check_eq($sformatf("%s_reg%0d", tag, i), 32'(regs_o[i*DATA_W +: DATA_W]), 32'(m_regs[i]));
    check_eq({tag, "_toggle"}, 32'(wr_toggle_o), 32'(m_toggle));
    check_eq({tag, "_last_addr"}, 32'(last_addr_o), 32'(m_last));
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cmd, input int ndata);
    do_frame(cmd, ndata, -1);
    model_frame(cmd, ndata);
    check_state(tag);
  endtask

  initial begin
    logic [7:0] cmd;
    int         nw;
    int         ndata;
    int         r;

    HRESETn    = 1'b0;
    spi_ss_i   = 1'b1;
    spi_mosi_i = 1'b0;
    model_reset();
    #12;
    check_eq("reset_miso", 32'(spi_miso_o), 32'd0);
    check_state("reset");
    HRESETn = 1'b1;
    #3;

    tx_words[0] = 16'h1108;
    run_frame("single_wr", 8'h03, DATA_W);
    check_eq("single_wr_reg3_const", 32'(regs_o[3*DATA_W +: DATA_W]), 32'h1108);
    check_eq("single_wr_toggle_const", 32'(wr_toggle_o), 32'd1);

    tx_words[0] = 16'hAAAA;
    tx_words[1] = 16'h5555;
    run_frame("burst_wrap", 8'h07, 2*DATA_W);
    check_eq("burst_reg0_const", 32'(regs_o[0 +: DATA_W]), 32'h5555);

    run_frame("burst_rd", 8'h83, 2*DATA_W);
    check_eq("burst_rd_word0_const", 32'(rx_words[0]), 32'h1108);
    check_eq("burst_rd_word1_const", 32'(rx_words[1]), 32'h0000);

    tx_words[0] = 16'h1234;
    run_frame("abort_wr", 8'h02, 12);
    tx_words[0] = 16'hBEEF;
    run_frame("after_abort", 8'h02, DATA_W);
    check_eq("after_abort_reg2_const", 32'(regs_o[2*DATA_W +: DATA_W]), 32'hBEEF);

    tx_words[0] = 16'h1234;
    run_frame("oor_wr", 8'h10, DATA_W);
    run_frame("oor_rd", 8'h90, 2*DATA_W);
    check_eq("oor_rd_miso_const", 32'(miso_any), 32'd0);

    for (int f = 0; f < 40; f++) begin
      cmd = 8'($urandom_range(0, 255));
      cmd[6:4] = 3'($urandom_range(0, 7) == 0 ? 1 : 0);
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) tx_words[w] = DATA_W'($urandom);
      r = $urandom_range(0, 7);
      if (r == 0)      ndata = -$urandom_range(1, 7);
      else if (r == 1) ndata = $urandom_range(1, nw*DATA_W - 1);
      else             ndata = nw*DATA_W;
      run_frame($sformatf("rand%0d", f), cmd, ndata);
    end

    tx_words[0] = 16'hC0DE;
    tx_words[1] = 16'hF00D;
    run_frame("pre_rst_fill", 8'h05, 2*DATA_W);
    do_frame(8'h01, 2*DATA_W, 20);
    model_reset();
    check_state("mid_burst_rst");
    tx_words[0] = 16'h0F0F;
    run_frame("post_rst_wr", 8'h06, DATA_W);
    run_frame("post_rst_rd", 8'h86, DATA_W);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
